// File: rtl/atri_i2c_bus_mux.sv
// rtl/atri_i2c_bus_mux.sv - N-way I2C bus switch with idle-gated switching and stuck-bus recovery
module atri_i2c_bus_mux #(
    parameter int NUM_BUS        = 4,
    parameter int IDLE_TICKS     = 4,
    parameter int SETTLE_TICKS   = 8,
    parameter int TIMEOUT_TICKS  = 1000,
    parameter int HALF_TICKS     = 5,
    parameter int RECOVER_PULSES = 9
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               MHz_CE_i,
    input  logic               ctl_wr_i,
    input  logic [7:0]         ctl_dat_i,
    output logic [7:0]         status_o,
    input  logic               scl_out_i,
    input  logic               sda_out_i,
    input  logic               scl_oen_i,
    input  logic               sda_oen_i,
    output logic               scl_in_o,
    output logic               sda_in_o,
    input  logic [NUM_BUS-1:0] scl_i,
    input  logic [NUM_BUS-1:0] sda_i,
    output logic [NUM_BUS-1:0] scl_oen_o,
    output logic [NUM_BUS-1:0] sda_oen_o
);

    typedef enum logic [2:0] {
        ST_CONNECTED,
        ST_WAIT_IDLE,
        ST_SWITCH,
        ST_SETTLE,
        ST_RECOVER,
        ST_STOP
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  sel_q, target_q;
    logic        rec_q;
    logic        err_range_q, err_busy_q, err_timeout_q, recover_fail_q;
    logic [15:0] idle_cnt_q, to_cnt_q, ph_cnt_q;
    logic [3:0]  pulse_cnt_q;
    logic        phase_hi_q;
    logic [1:0]  stop_ph_q;

    logic [7:0]  scl_ext, sda_ext;
    logic        scl_bus, sda_bus;
    logic        pass, range_bad, idle_cond;
    logic        idle_done, to_done, settle_end, half_end, pulse_last;
    logic        rec_scl, rec_sda, scl_drv, sda_drv;

    // Pad data is always 0 on open-drain lines; control bits [6:3] are reserved.
    logic unused_in;
    assign unused_in = scl_out_i ^ sda_out_i ^ (^ctl_dat_i[6:3]);

    // Widen bus inputs to 8 so the 3-bit select always indexes in range.
    always_comb begin
        scl_ext = 8'hFF;
        sda_ext = 8'hFF;
        for (int i = 0; i < NUM_BUS; i++) begin
            scl_ext[i] = scl_i[i];
            sda_ext[i] = sda_i[i];
        end
    end

    assign scl_bus    = scl_ext[sel_q];
    assign sda_bus    = sda_ext[sel_q];
    assign pass       = (state_q == ST_CONNECTED) || (state_q == ST_WAIT_IDLE);
    assign range_bad  = 32'(ctl_dat_i[2:0]) >= 32'(NUM_BUS);
    assign idle_cond  = scl_oen_i & sda_oen_i & scl_bus & sda_bus;
    assign idle_done  = (state_q == ST_WAIT_IDLE) && MHz_CE_i && idle_cond &&
                        (idle_cnt_q == 16'(IDLE_TICKS - 1));
    assign to_done    = (state_q == ST_WAIT_IDLE) && MHz_CE_i &&
                        (to_cnt_q == 16'(TIMEOUT_TICKS - 1));
    assign settle_end = (state_q == ST_SETTLE) && MHz_CE_i &&
                        (ph_cnt_q == 16'(SETTLE_TICKS - 1));
    assign half_end   = ((state_q == ST_RECOVER) || (state_q == ST_STOP)) && MHz_CE_i &&
                        (ph_cnt_q == 16'(HALF_TICKS - 1));
    assign pulse_last = (pulse_cnt_q == 4'(RECOVER_PULSES - 1));

    // State register; reset releases every line immediately.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= ST_CONNECTED;
        else          state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CONNECTED: if (ctl_wr_i && !range_bad) state_d = ST_WAIT_IDLE;
            ST_WAIT_IDLE: begin
                if (idle_done)    state_d = ST_SWITCH;
                else if (to_done) state_d = ST_CONNECTED;
            end
            ST_SWITCH:    state_d = rec_q ? ST_RECOVER : ST_SETTLE;
            ST_SETTLE:    if (settle_end) state_d = ST_CONNECTED;
            ST_RECOVER:   if (half_end && phase_hi_q && (sda_bus || pulse_last)) state_d = ST_STOP;
            ST_STOP:      if (half_end && (stop_ph_q == 2'd2)) state_d = ST_SETTLE;
            default:      state_d = ST_CONNECTED;
        endcase
    end

    // Control latch, sticky status, timers and recovery sequencing.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sel_q          <= 3'd0;
            target_q       <= 3'd0;
            rec_q          <= 1'b0;
            err_range_q    <= 1'b0;
            err_busy_q     <= 1'b0;
            err_timeout_q  <= 1'b0;
            recover_fail_q <= 1'b0;
            idle_cnt_q     <= 16'd0;
            to_cnt_q       <= 16'd0;
            ph_cnt_q       <= 16'd0;
            pulse_cnt_q    <= 4'd0;
            phase_hi_q     <= 1'b0;
            stop_ph_q      <= 2'd0;
        end else begin
            if (ctl_wr_i) begin
                if (state_q == ST_CONNECTED) begin
                    err_busy_q     <= 1'b0;
                    err_timeout_q  <= 1'b0;
                    recover_fail_q <= 1'b0;
                    err_range_q    <= range_bad;
                    if (!range_bad) begin
                        target_q <= ctl_dat_i[2:0];
                        rec_q    <= ctl_dat_i[7];
                    end
                end else begin
                    err_busy_q <= 1'b1;
                end
            end
            if (state_q == ST_WAIT_IDLE) begin
                if (!idle_cond)    idle_cnt_q <= 16'd0;
                else if (MHz_CE_i) idle_cnt_q <= idle_cnt_q + 16'd1;
                if (MHz_CE_i)      to_cnt_q   <= to_cnt_q + 16'd1;
                if (to_done && !idle_done) err_timeout_q <= 1'b1;
            end else begin
                idle_cnt_q <= 16'd0;
                to_cnt_q   <= 16'd0;
            end
            if (state_q == ST_SWITCH) begin
                sel_q       <= target_q;
                phase_hi_q  <= 1'b0;
                pulse_cnt_q <= 4'd0;
                stop_ph_q   <= 2'd0;
            end
            // Phase timer restarts on every state change and every half period.
            if (state_d != state_q) ph_cnt_q <= 16'd0;
            else if (MHz_CE_i)      ph_cnt_q <= half_end ? 16'd0 : ph_cnt_q + 16'd1;
            if ((state_q == ST_RECOVER) && half_end) begin
                if (!phase_hi_q) begin
                    phase_hi_q <= 1'b1;
                end else if (!sda_bus) begin
                    pulse_cnt_q <= pulse_cnt_q + 4'd1;
                    phase_hi_q  <= 1'b0;
                    if (pulse_last) recover_fail_q <= 1'b1;
                end
            end
            if ((state_q == ST_STOP) && half_end) stop_ph_q <= stop_ph_q + 2'd1;
        end
    end

    // Line drive while the master is isolated: SCL toggling, then the STOP pattern.
    always_comb begin
        rec_scl = 1'b1;
        rec_sda = 1'b1;
        if (state_q == ST_RECOVER) begin
            rec_scl = phase_hi_q;
        end else if (state_q == ST_STOP) begin
            rec_scl = (stop_ph_q != 2'd0);
            rec_sda = (stop_ph_q == 2'd2);
        end
    end

    assign scl_drv  = pass ? scl_oen_i : rec_scl;
    assign sda_drv  = pass ? sda_oen_i : rec_sda;
    assign scl_in_o = pass ? scl_bus : 1'b1;
    assign sda_in_o = pass ? sda_bus : 1'b1;

    for (genvar i = 0; i < NUM_BUS; i++) begin : g_bus
        assign scl_oen_o[i] = (sel_q == 3'(i)) ? scl_drv : 1'b1;
        assign sda_oen_o[i] = (sel_q == 3'(i)) ? sda_drv : 1'b1;
    end

    assign status_o = {recover_fail_q, err_timeout_q, err_busy_q, err_range_q,
                       (state_q != ST_CONNECTED), sel_q};

endmodule

// File: tb/tb_atri_i2c_bus_mux.sv
// tb/tb_atri_i2c_bus_mux.sv - directed self-checking bench for atri_i2c_bus_mux
module tb_atri_i2c_bus_mux;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ce = 1'b0;
    logic       ctl_wr = 1'b0;
    logic [7:0] ctl_dat = 8'h00;
    logic [7:0] status;
    logic       scl_oen_m = 1'b1, sda_oen_m = 1'b1;
    logic       scl_in, sda_in;
    logic [3:0] scl_bus, sda_bus, scl_oen, sda_oen;
    logic [3:0] scl_hold = 4'h0, sda_hold = 4'h0;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int tick_total = 0;
    int t0 = 0;
    int pulses, stops, n;

    // Wired-AND buses with pull-ups; a hold bit models a stuck slave.
    assign scl_bus = scl_oen & ~scl_hold;
    assign sda_bus = sda_oen & ~sda_hold;

    atri_i2c_bus_mux dut (
        .clk_i(clk), .rst_n_i(rst_n), .MHz_CE_i(ce),
        .ctl_wr_i(ctl_wr), .ctl_dat_i(ctl_dat), .status_o(status),
        .scl_out_i(1'b0), .sda_out_i(1'b0),
        .scl_oen_i(scl_oen_m), .sda_oen_i(sda_oen_m),
        .scl_in_o(scl_in), .sda_in_o(sda_in),
        .scl_i(scl_bus), .sda_i(sda_bus),
        .scl_oen_o(scl_oen), .sda_oen_o(sda_oen)
    );

    always #5 clk = ~clk;

    // One tick every 4 clocks, changed on the falling edge.
    always @(negedge clk) begin
        cyc++;
        ce = (cyc % 4 == 0);
    end

    always @(posedge clk) if (ce) tick_total++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_ctl(input logic [7:0] d);
        @(negedge clk);
        ctl_dat = d;
        ctl_wr = 1'b1;
        @(posedge clk);
        #1 t0 = tick_total;
        @(negedge clk);
        ctl_wr = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (status[3] === 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_wait"}, 32'(k >= budget), 0);
    endtask

    task automatic run_recover(input int bus, input int release_at,
                               output int p, output int s);
        int k = 0;
        logic ps, pd;
        p = 0;
        s = 0;
        while (scl_oen[bus] !== 1'b0 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("rec_start", 32'(k >= 2000), 0);
        sda_hold[bus] = 1'b1;
        check("rec_isolated", {30'd0, scl_in, sda_in}, 2'b11);
        ps = scl_oen[bus];
        pd = sda_oen[bus];
        while (status[3] === 1'b1 && k < 4000) begin
            @(negedge clk);
            k++;
            if (scl_oen[bus] && !ps && sda_oen[bus]) begin
                p++;
                if (p == release_at) sda_hold[bus] = 1'b0;
            end
            if (sda_oen[bus] && !pd && scl_oen[bus]) s++;
            ps = scl_oen[bus];
            pd = sda_oen[bus];
        end
        sda_hold[bus] = 1'b0;
        check("rec_wait", 32'(k >= 4000), 0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_status", status, 8'h00);
        check("rst_scl_oen", scl_oen, 4'hF);
        check("rst_sda_oen", sda_oen, 4'hF);
        check("rst_in", {scl_in, sda_in}, 2'b11);
        rst_n = 1'b1;
        @(negedge clk);

        // Passthrough on bus 0
        scl_oen_m = 1'b0;
        #1 check("p0_scl_oen", scl_oen, 4'hE);
        check("p0_scl_in", scl_in, 1'b0);
        check("p0_sda_oen", sda_oen, 4'hF);
        scl_oen_m = 1'b1;
        sda_oen_m = 1'b0;
        #1 check("p0_sda_oen2", sda_oen, 4'hE);
        check("p0_sda_in", sda_in, 1'b0);
        sda_oen_m = 1'b1;

        // Out of range target
        write_ctl(8'h05);
        check("range_status", status, 8'h10);

        // Switch to bus 2 with timing
        write_ctl(8'h02);
        check("sw2_busy", status, 8'h08);
        check("sw2_isolated_oen", scl_oen, 4'hF);
        wait_done("sw2", 200);
        check("sw2_ticks", tick_total - t0, 12);
        check("sw2_status", status, 8'h02);
        scl_oen_m = 1'b0;
        #1 check("sw2_scl_oen", scl_oen, 4'hB);
        scl_oen_m = 1'b1;
        sda_oen_m = 1'b0;
        #1 check("sw2_sda_oen", sda_oen, 4'hB);
        check("sw2_sda_in", sda_in, 1'b0);
        sda_oen_m = 1'b1;

        // Switch to bus 1
        write_ctl(8'h01);
        wait_done("sw1", 200);
        check("sw1_status", status, 8'h01);

        // Idle never reached: timeout
        sda_hold[1] = 1'b1;
        write_ctl(8'h03);
        wait_done("to", 6000);
        check("to_ticks", tick_total - t0, 1000);
        check("to_status", status, 8'h41);
        sda_hold[1] = 1'b0;

        // Recovery, SDA freed during the third pulse
        write_ctl(8'h81);
        run_recover(1, 3, pulses, stops);
        check("recA_pulses", pulses, 3);
        check("recA_stop", stops, 1);
        check("recA_status", status, 8'h01);

        // Recovery, SDA stuck permanently
        write_ctl(8'h81);
        run_recover(1, 0, pulses, stops);
        check("recB_pulses", pulses, 9);
        check("recB_stop", stops, 1);
        check("recB_status", status, 8'h81);

        // Write while busy during settle
        write_ctl(8'h00);
        n = 0;
        while (tick_total < t0 + 8 && n < 200) begin
            @(negedge clk);
            n++;
        end
        write_ctl(8'h03);
        check("busy_status", status, 8'h28);
        wait_done("busy", 200);
        check("busy_final", status, 8'h20);

        // Reset in the middle of recovery
        write_ctl(8'h82);
        n = 0;
        while (scl_oen[2] !== 1'b0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("rr_start", 32'(n >= 500), 0);
        sda_hold[2] = 1'b1;
        repeat (10) @(negedge clk);
        check("rr_pre_status", status, 8'h0A);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check("rr_scl_oen", scl_oen, 4'hF);
        check("rr_sda_oen", sda_oen, 4'hF);
        check("rr_status", status, 8'h00);
        check("rr_in", {scl_in, sda_in}, 2'b11);
        @(negedge clk);
        rst_n = 1'b1;
        sda_hold[2] = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
